// File: rtl/reg_index_encoder_32_if.sv
// Handshake bundle for reg_index_encoder_32: mask load channel, index output channel and status.
// master drives the mask and consumes indices; slave is the encoder itself.
interface reg_index_encoder_32_if;
    logic        load_valid;
    logic        load_ready;
    logic [31:0] load_mask;
    logic        abort;
    logic        idx_valid;
    logic        idx_ready;
    logic [4:0]  idx;
    logic        idx_last;
    logic [5:0]  remaining;
    logic        busy;

    modport master (
        output load_valid, load_mask, abort, idx_ready,
        input  load_ready, idx_valid, idx, idx_last, remaining, busy
    );

    modport slave (
        input  load_valid, load_mask, abort, idx_ready,
        output load_ready, idx_valid, idx, idx_last, remaining, busy
    );
endinterface

// File: rtl/reg_index_encoder_32.sv
// Sequential 32-to-5 index encoder: drains a register bitmap one set-bit index per handshake,
// lowest index first. Outputs are decoded purely from registered state.
module reg_index_encoder_32 (
    input  logic                    clock,
    input  logic                    reset_n,
    reg_index_encoder_32_if.slave   bus
);
    // Both channels are valid/ready: a beat moves on a rising edge where valid and ready are both 1;
    // the producer holds its payload stable until then, and abort cancels any beat in its cycle.
    typedef enum logic {IDLE, EMIT} state_t;

    state_t      state_q, state_d;
    logic [31:0] pending_q, pending_d;
    logic [5:0]  remaining_q, remaining_d;
    logic [4:0]  lowest;

    function automatic logic [4:0] lsb_index(input logic [31:0] v);
        lsb_index = 5'd0;
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) lsb_index = 5'(i);
        end
    endfunction

    function automatic logic [5:0] popcount(input logic [31:0] v);
        popcount = 6'd0;
        for (int i = 0; i < 32; i++) begin
            popcount = popcount + {5'd0, v[i]};
        end
    endfunction

    assign lowest = lsb_index(pending_q);

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        remaining_d = remaining_q;
        if (bus.abort) begin
            state_d     = IDLE;
            pending_d   = 32'd0;
            remaining_d = 6'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.load_valid) begin
                        pending_d   = bus.load_mask;
                        remaining_d = popcount(bus.load_mask);
                        state_d     = (bus.load_mask != 32'd0) ? EMIT : IDLE;
                    end
                end
                EMIT: begin
                    if (bus.idx_ready) begin
                        // Clearing the lowest set bit is exactly the bit just transferred.
                        pending_d   = pending_q & (pending_q - 32'd1);
                        remaining_d = remaining_q - 6'd1;
                        if (remaining_q == 6'd1) state_d = IDLE;
                    end
                end
                default: begin
                    state_d     = IDLE;
                    pending_d   = 32'd0;
                    remaining_d = 6'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            pending_q   <= 32'd0;
            remaining_q <= 6'd0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            remaining_q <= remaining_d;
        end
    end

    always_comb begin
        bus.load_ready = (state_q == IDLE);
        bus.idx_valid  = (state_q == EMIT);
        bus.busy       = (state_q == EMIT);
        bus.idx        = (state_q == EMIT) ? lowest : 5'd0;
        bus.idx_last   = (state_q == EMIT) && (remaining_q == 6'd1);
        bus.remaining  = remaining_q;
    end
endmodule

// File: tb/tb_reg_index_encoder_32.sv
// Directed bench for reg_index_encoder_32: expected (idx, idx_last, remaining) beats are queued
// when a mask is loaded and popped on every observed transfer.
module tb_reg_index_encoder_32;
    logic clock = 1'b0;
    logic reset_n;

    always #5 clock = ~clock;

    reg_index_encoder_32_if bus ();

    reg_index_encoder_32 dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    int errors = 0;
    int checks = 0;
    int xfers  = 0;
    logic [11:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_mask(input logic [31:0] m);
        int rem;
        rem = $countones(m);
        for (int i = 0; i < 32; i++) begin
            if (m[i]) begin
                exp_q.push_back({i[4:0], (rem == 1), rem[5:0]});
                rem--;
            end
        end
    endtask

    // Advances one clock; a transfer about to happen on this edge is scored first.
    task automatic tick();
        logic [11:0] e;
        if (bus.idx_valid && bus.idx_ready && !bus.abort) begin
            xfers++;
            check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("idx", 32'(bus.idx), 32'(e[11:7]));
                check("idx_last", 32'(bus.idx_last), 32'(e[6]));
                check("remaining", 32'(bus.remaining), 32'(e[5:0]));
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic load(input logic [31:0] m);
        check("load_ready_before_load", 32'(bus.load_ready), 32'd1);
        bus.load_valid = 1'b1;
        bus.load_mask  = m;
        push_mask(m);
        tick();
        bus.load_valid = 1'b0;
        bus.load_mask  = 32'd0;
    endtask

    task automatic drain(input int expected_cycles);
        int n;
        n = 0;
        bus.idx_ready = 1'b1;
        while (bus.idx_valid && n < 40) begin
            tick();
            n++;
        end
        check("drain_done", 32'(bus.idx_valid), 32'd0);
        check("drain_cycles", 32'(n), 32'(expected_cycles));
        check("sb_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int x0;
        bus.load_valid = 1'b0;
        bus.load_mask  = 32'd0;
        bus.abort      = 1'b0;
        bus.idx_ready  = 1'b0;
        reset_n        = 1'b0;
        repeat (2) @(posedge clock);
        #3 reset_n = 1'b1;
        @(posedge clock);
        #1;

        check("rst_load_ready", 32'(bus.load_ready), 32'd1);
        check("rst_idx_valid", 32'(bus.idx_valid), 32'd0);
        check("rst_idx", 32'(bus.idx), 32'd0);
        check("rst_idx_last", 32'(bus.idx_last), 32'd0);
        check("rst_remaining", 32'(bus.remaining), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);

        // Basic drain
        load(32'h8001_0005);
        check("basic_remaining_first", 32'(bus.remaining), 32'd4);
        check("basic_busy", 32'(bus.busy), 32'd1);
        check("basic_load_ready_low", 32'(bus.load_ready), 32'd0);
        drain(4);
        check("basic_load_ready_after", 32'(bus.load_ready), 32'd1);

        // Backpressure
        bus.idx_ready = 1'b0;
        x0 = xfers;
        load(32'h0000_0006);
        for (int i = 0; i < 3; i++) begin
            check("bp_idx_held", 32'(bus.idx), 32'd1);
            check("bp_remaining_held", 32'(bus.remaining), 32'd2);
            check("bp_last_low", 32'(bus.idx_last), 32'd0);
            tick();
        end
        drain(2);
        check("bp_transfers", 32'(xfers - x0), 32'd2);

        // Full then zero masks, including back-to-back zero loads
        load(32'hFFFF_FFFF);
        check("full_remaining_first", 32'(bus.remaining), 32'd32);
        drain(32);
        load(32'h0000_0000);
        check("zero_idx_valid", 32'(bus.idx_valid), 32'd0);
        check("zero_busy", 32'(bus.busy), 32'd0);
        load(32'h0000_0000);
        check("zero2_idx_valid", 32'(bus.idx_valid), 32'd0);
        check("zero2_load_ready", 32'(bus.load_ready), 32'd1);

        // Abort wins over a simultaneous transfer and load
        bus.idx_ready = 1'b1;
        load(32'h0000_0F00);
        tick();
        check("abort_idx_presented", 32'(bus.idx), 32'd9);
        bus.abort      = 1'b1;
        bus.load_valid = 1'b1;
        bus.load_mask  = 32'h0000_0001;
        tick();
        exp_q.delete();
        bus.abort      = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_mask  = 32'd0;
        check("abort_idx_valid", 32'(bus.idx_valid), 32'd0);
        check("abort_remaining", 32'(bus.remaining), 32'd0);
        check("abort_load_ready", 32'(bus.load_ready), 32'd1);
        tick();
        check("abort_no_capture", 32'(bus.idx_valid), 32'd0);

        // Load held high during EMIT is ignored until load_ready returns
        x0 = xfers;
        bus.idx_ready  = 1'b1;
        bus.load_valid = 1'b1;
        bus.load_mask  = 32'h0000_0030;
        push_mask(32'h0000_0030);
        tick();
        bus.load_mask  = 32'h0000_0001;
        tick();
        tick();
        check("ign_load_ready_back", 32'(bus.load_ready), 32'd1);
        check("ign_idle_gap", 32'(bus.idx_valid), 32'd0);
        push_mask(32'h0000_0001);
        tick();
        bus.load_valid = 1'b0;
        check("ign_new_idx", 32'(bus.idx), 32'd0);
        check("ign_new_last", 32'(bus.idx_last), 32'd1);
        drain(1);
        check("ign_transfers", 32'(xfers - x0), 32'd3);

        // Asynchronous reset mid-EMIT
        bus.idx_ready = 1'b1;
        load(32'h00FF_0000);
        tick();
        #2 reset_n = 1'b0;
        #1;
        exp_q.delete();
        check("arst_load_ready", 32'(bus.load_ready), 32'd1);
        check("arst_idx_valid", 32'(bus.idx_valid), 32'd0);
        check("arst_idx", 32'(bus.idx), 32'd0);
        check("arst_remaining", 32'(bus.remaining), 32'd0);
        check("arst_busy", 32'(bus.busy), 32'd0);
        @(posedge clock);
        #3 reset_n = 1'b1;
        @(posedge clock);
        #1;
        tick();
        check("arst_stays_idle", 32'(bus.idx_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
